// File: rtl/ps2_host_tx_if.sv
// ps2_host_tx_if: command handshake, PS/2 pin levels and status of the PS/2 host transmitter.
interface ps2_host_tx_if;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       ps2_clk_in;
    logic       ps2_data_in;
    logic       ps2_clk_oe;
    logic       ps2_data_oe;
    logic       busy;
    logic       done;
    logic       err;
    modport master (
        output tx_valid, tx_data, ps2_clk_in, ps2_data_in,
        input  tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err
    );
    modport slave (
        input  tx_valid, tx_data, ps2_clk_in, ps2_data_in,
        output tx_ready, ps2_clk_oe, ps2_data_oe, busy, done, err
    );
endinterface

// File: rtl/ps2_host_tx.sv
// ps2_host_tx: sends one command byte to a PS/2 device (inhibit, request-to-send, 11 device clocks, ack check).
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input logic           clk,
    input logic           rst,
    ps2_host_tx_if.slave  bus
);
    localparam int IW = $clog2(INHIBIT_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK_WAIT, RELEASE} state_t;
    state_t        state;
    logic [1:0]    clk_sync;
    logic [1:0]    data_sync;
    logic          fall;
    logic [9:0]    frame;
    logic [3:0]    idx;
    logic [IW-1:0] inh_cnt;
    logic [TW-1:0] to_cnt;
    logic          timeout;
    logic          timed;
    assign timeout = to_cnt == TW'(TIMEOUT_CYCLES - 1);
    assign timed   = state == REQ || state == SEND || state == ACK_WAIT || state == RELEASE;
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync         <= 2'b11;
            data_sync        <= 2'b11;
            fall             <= 1'b0;
            state            <= IDLE;
            frame            <= '0;
            idx              <= '0;
            inh_cnt          <= '0;
            to_cnt           <= '0;
            bus.ps2_clk_oe   <= 1'b0;
            bus.ps2_data_oe  <= 1'b0;
            bus.busy         <= 1'b0;
            bus.done         <= 1'b0;
            bus.err          <= 1'b0;
            bus.tx_ready     <= 1'b1;
        end else begin
            clk_sync  <= {clk_sync[0], bus.ps2_clk_in};
            data_sync <= {data_sync[0], bus.ps2_data_in};
            // pulse lands on the same edge the synced clock drops
            fall      <= clk_sync[1] & ~clk_sync[0];
            bus.done  <= 1'b0;
            bus.err   <= 1'b0;
            if (timed && !timeout)
                to_cnt <= to_cnt + 1'b1;
            if (timed && timeout) begin
                state           <= IDLE;
                bus.ps2_clk_oe  <= 1'b0;
                bus.ps2_data_oe <= 1'b0;
                bus.err         <= 1'b1;
                bus.busy        <= 1'b0;
                bus.tx_ready    <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (bus.tx_valid) begin
                        frame          <= {1'b1, ~^bus.tx_data, bus.tx_data};
                        inh_cnt        <= '0;
                        state          <= INHIBIT;
                        bus.ps2_clk_oe <= 1'b1;
                        bus.busy       <= 1'b1;
                        bus.tx_ready   <= 1'b0;
                    end
                    INHIBIT: if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                        state           <= REQ;
                        bus.ps2_clk_oe  <= 1'b0;
                        bus.ps2_data_oe <= 1'b1;
                        to_cnt          <= '0;
                    end else begin
                        inh_cnt <= inh_cnt + 1'b1;
                    end
                    REQ: begin
                        state <= SEND;
                        idx   <= '0;
                    end
                    SEND: if (fall) begin
                        bus.ps2_data_oe <= ~frame[idx];
                        if (idx == 4'd9)
                            state <= ACK_WAIT;
                        else
                            idx <= idx + 1'b1;
                    end
                    ACK_WAIT: if (fall) begin
                        if (!data_sync[1]) begin
                            state <= RELEASE;
                        end else begin
                            state        <= IDLE;
                            bus.err      <= 1'b1;
                            bus.busy     <= 1'b0;
                            bus.tx_ready <= 1'b1;
                        end
                    end
                    RELEASE: if (clk_sync[1] && data_sync[1]) begin
                        state        <= IDLE;
                        bus.done     <= 1'b1;
                        bus.busy     <= 1'b0;
                        bus.tx_ready <= 1'b1;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: PS/2 device model clocking the host transmitter, with per-cycle output checks.
module tb_ps2_host_tx;
    localparam int INH = 20;
    localparam int TMO = 3000;
    localparam logic [10:0] ED_LIT = 11'b111_1101_1010;
    logic clk = 0;
    logic rst = 1;
    logic dev_clk = 1;
    logic dev_data = 1;
    logic chk_en = 0;
    logic b2b = 0;
    logic prev_coe = 0;
    logic [10:0] samp;
    int cyc = 0;
    int run = 0;
    int exp_done = -10;
    int exp_err = -10;
    int total = 0;
    int bad = 0;
    ps2_host_tx_if ifc ();
    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TMO)) dut (.clk(clk), .rst(rst), .bus(ifc));
    assign ifc.ps2_clk_in  = dev_clk & ~ifc.ps2_clk_oe;
    assign ifc.ps2_data_in = dev_data & ~ifc.ps2_data_oe;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    task automatic send(input logic [7:0] b);
        int k = 0;
        while (!ifc.tx_ready && k < 100) begin
            step();
            k++;
        end
        chk("ready_wait", 32'(k < 100), 1);
        ifc.tx_valid = 1;
        ifc.tx_data  = b;
        step();
        ifc.tx_valid = 0;
    endtask

    // mode 0: ack, 1: no ack, 2: never clocks, 3: stops after fall 5
    task automatic dev_frame(input logic [7:0] b, input int mode);
        int k = 0;
        int ones = 0;
        logic par;
        logic [10:0] e;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2) == 0;
        e = {1'b1, par, b, 1'b0};
        while (!(ifc.ps2_data_oe && !ifc.ps2_clk_oe) && k < 200) begin
            step();
            k++;
        end
        chk("req_seen", 32'(k < 200), 1);
        if (mode == 2) begin
            exp_err = cyc + TMO;
            repeat (TMO + 10) step();
            return;
        end
        repeat (5) step();
        samp[0] = ifc.ps2_data_in;
        for (int i = 1; i <= 10; i++) begin
            dev_clk = 0;
            repeat (20) step();
            if (mode == 3 && i == 5) return;
            dev_clk = 1;
            samp[i] = ifc.ps2_data_in;
            repeat (20) step();
        end
        for (int i = 0; i < 11; i++) chk($sformatf("bit%0d", i), 32'(samp[i]), 32'(e[i]));
        dev_clk = 0;
        if (mode == 0) dev_data = 0;
        if (mode == 1) exp_err = cyc + 3;
        repeat (20) step();
        dev_clk = 1;
        repeat (5) step();
        if (mode == 0) begin
            dev_data = 1;
            exp_done = cyc + 3;
        end
        repeat (10) step();
    endtask

    initial begin
        ifc.tx_valid = 0;
        ifc.tx_data  = 0;
        fork
            forever begin
                @(negedge clk);
                if (chk_en) begin
                    chk("done", 32'(ifc.done), 32'(cyc == exp_done));
                    chk("err", 32'(ifc.err), 32'(cyc == exp_err));
                    chk("busy_vs_ready", 32'(ifc.busy), 32'(!ifc.tx_ready));
                    if (!ifc.busy) chk("idle_lines", 32'({ifc.ps2_clk_oe, ifc.ps2_data_oe}), 0);
                    if (prev_coe && !ifc.ps2_clk_oe) begin
                        chk("inhibit_len", run, INH);
                        chk("req_data_oe", 32'(ifc.ps2_data_oe), 1);
                    end
                    if (b2b && cyc == exp_done + 1) chk("b2b_accept", 32'(ifc.ps2_clk_oe), 1);
                    run = ifc.ps2_clk_oe ? run + 1 : 0;
                    prev_coe = ifc.ps2_clk_oe;
                end
            end
        join_none
        repeat (3) step();
        chk("rst_ready", 32'(ifc.tx_ready), 1);
        chk("rst_busy", 32'(ifc.busy), 0);
        chk("rst_oe", 32'({ifc.ps2_clk_oe, ifc.ps2_data_oe}), 0);
        chk("rst_pulses", 32'({ifc.done, ifc.err}), 0);
        rst = 0;
        chk_en = 1;
        step();
        send(8'hED);
        dev_frame(8'hED, 0);
        chk("ed_frame", 32'(samp), 32'(ED_LIT));
        send(8'h00);
        dev_frame(8'h00, 0);
        chk("par_00", 32'(samp[9]), 1);
        send(8'h01);
        dev_frame(8'h01, 0);
        chk("par_01", 32'(samp[9]), 0);
        send(8'h3C);
        dev_frame(8'h3C, 1);
        chk("noack_ready", 32'(ifc.tx_ready), 1);
        send(8'h55);
        dev_frame(8'h55, 2);
        chk("tmo_oe", 32'({ifc.ps2_clk_oe, ifc.ps2_data_oe}), 0);
        chk("tmo_ready", 32'(ifc.tx_ready), 1);
        send(8'hA5);
        dev_frame(8'hA5, 3);
        rst = 1;
        step();
        rst = 0;
        chk("abort_oe", 32'({ifc.ps2_clk_oe, ifc.ps2_data_oe}), 0);
        chk("abort_busy", 32'(ifc.busy), 0);
        dev_clk = 1;
        repeat (5) step();
        send(8'hFF);
        dev_frame(8'hFF, 0);
        b2b = 1;
        ifc.tx_valid = 1;
        ifc.tx_data  = 8'hF4;
        step();
        ifc.tx_data = 8'hED;
        dev_frame(8'hF4, 0);
        b2b = 0;
        ifc.tx_valid = 0;
        dev_frame(8'hED, 0);
        chk("b2b_second", 32'(samp), 32'(ED_LIT));
        repeat (5) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
